card_flip_ctrl: RTL and testbench
=================================

// Module: card_flip_ctrl
// PURPOSE
//  Game sequencer for the 16-card flip board. Requests a shuffle from the random
//  assigner, latches the 48-bit card map, and accepts player card selections two at a time.
//  Compares each pair, records matches, holds a mismatched pair face-up for a display
//  interval, counts attempts and flags the win. Sits between input decode and the VGA/HEX drivers.
// PARAMETERS
//  SHOW_CYCLES  25_000_000  cycles a mismatched pair stays face-up (>=1)
// PORTS
//  clk           in   1   system clock
//  reset         in   1   asynchronous, active-high reset
//  new_game      in   1   1-cycle strobe: (re)start a game
//  sel_valid     in   1   1-cycle strobe: player selects card sel_idx
//  sel_idx       in   4   selected card index 0..15
//  map           in   48  card values from assigner; card i value = map[3*i +: 3]
//  map_done      in   1   1-cycle strobe: map is valid this cycle
//  shuffle_start out  1   1-cycle strobe to assigner start input
//  face_up       out  16  bit i = card i shown (matched cards stay 1)
//  matched       out  16  bit i = card i permanently matched
//  attempts      out  8   pairs flipped this game, saturates at 255
//  pairs_found   out  4   0..8
//  sel_reject    out  1   1-cycle pulse: sel_valid ignored
//  busy          out  1   1 in WAIT_MAP, COMPARE, SHOW
//  win           out  1   1 while in WIN
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; every output 0; latched map, first/second idx, timer cleared.
//  - All registered; outputs change on the clk edge after the causing input.
//  - new_game has priority over sel_valid in every state. Accepted in IDLE, PICK1, PICK2,
//    COMPARE, SHOW, WIN (aborts the game in progress). Ignored in WAIT_MAP.
//    On accept: shuffle_start=1 for one cycle; face_up, matched, attempts, pairs_found cleared;
//    go to WAIT_MAP.
//  - WAIT_MAP: on map_done, latch map into an internal register and go to PICK1.
//    Later map changes never affect the game in progress.
//  - PICK1: a sel_valid on a card with face_up[idx]=1 is rejected (sel_reject pulse, no state change).
//    Otherwise set face_up[idx], store first=idx, go to PICK2.
//  - PICK2: reject sel_idx==first or any face-up card. Otherwise set face_up[idx], store second=idx,
//    increment attempts (hold at 255), go to COMPARE.
//  - COMPARE (exactly 1 cycle): compare 3-bit values of first and second.
//      equal:   set matched on both cards and increment pairs_found. If the new count is 8 go to WIN,
//               else go to PICK1.
//      unequal: load timer=SHOW_CYCLES-1 and go to SHOW.
//  - SHOW: decrement timer each cycle. Both cards stay face-up for exactly SHOW_CYCLES cycles after
//    COMPARE. At timer==0, clear face_up on both cards and go to PICK1.
//  - sel_valid in WAIT_MAP/COMPARE/SHOW/WIN/IDLE: rejected (sel_reject pulse).
//  - WIN: win=1 and all face_up/matched bits are 1. Held until new_game or reset.
//  - Legal sequence: IDLE->WAIT_MAP->PICK1->PICK2->COMPARE->(PICK1|SHOW|WIN); SHOW->PICK1.
//  - Unused state encodings recover to IDLE.
// TESTING
//  Reference map M: card i value = i>>1 (cards 2k and 2k+1 pair).
//  1 Reset mid-SHOW -> next cycle all outputs 0, state IDLE; sel_valid gives sel_reject=1.
//  2 new_game, then map_done with M -> one shuffle_start pulse; busy until map_done.
//    Select 0 then 1 -> matched=16'h0003, pairs_found=1, attempts=1, back to PICK1.
//  3 Select 2 then 4 (SHOW_CYCLES=4) -> face_up bits 2,4 set for exactly 4 cycles then cleared.
//    sel_valid during SHOW rejected. attempts increments.
//  4 Reselect the same card in PICK2, and select an already-matched card -> sel_reject pulses,
//    attempts unchanged.
//  5 Play all 8 pairs correctly -> win=1, matched=face_up=16'hFFFF, pairs_found=8, attempts=8.
//    new_game -> all cleared, shuffle_start pulse.
//  6 260 mismatches -> attempts stays at 255. new_game with simultaneous sel_valid in PICK2 ->
//    restart taken, selection dropped.

Source files
------------

// File: rtl/card_flip_ctrl.sv
// card_flip_ctrl: 16-card flip game sequencer (shuffle request, pair compare, mismatch display, win)
module card_flip_ctrl #(
  parameter int SHOW_CYCLES = 25_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_game,
  input  logic        sel_valid,
  input  logic [3:0]  sel_idx,
  input  logic [47:0] map,
  input  logic        map_done,
  output logic        shuffle_start,
  output logic [15:0] face_up,
  output logic [15:0] matched,
  output logic [7:0]  attempts,
  output logic [3:0]  pairs_found,
  output logic        sel_reject,
  output logic        busy,
  output logic        win
);
  localparam int TW = SHOW_CYCLES > 1 ? $clog2(SHOW_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, WAIT_MAP, PICK1, PICK2, COMPARE, SHOW, WIN} state_t;
  state_t state, state_n;
  logic [47:0] map_q, map_n;
  logic [3:0] first, first_n, second, second_n, pairs_n;
  logic [TW-1:0] timer, timer_n;
  logic [15:0] face_n, matched_n;
  logic [7:0] att_n;
  logic ss_n, rej_n;
  logic [2:0] val_a, val_b;
  assign val_a = map_q[3*first +: 3];
  assign val_b = map_q[3*second +: 3];
  always_comb begin
    state_n = state;
    map_n = map_q;
    first_n = first;
    second_n = second;
    timer_n = timer;
    face_n = face_up;
    matched_n = matched;
    att_n = attempts;
    pairs_n = pairs_found;
    ss_n = 1'b0;
    rej_n = 1'b0;
    if (new_game && state != WAIT_MAP) begin
      state_n = WAIT_MAP;
      ss_n = 1'b1;
      face_n = '0;
      matched_n = '0;
      att_n = '0;
      pairs_n = '0;
      rej_n = sel_valid;
    end else begin
      case (state)
        IDLE: rej_n = sel_valid;
        WAIT_MAP: begin
          rej_n = sel_valid;
          if (map_done) begin
            map_n = map;
            state_n = PICK1;
          end
        end
        PICK1: if (sel_valid) begin
          if (face_up[sel_idx]) rej_n = 1'b1;
          else begin
            face_n[sel_idx] = 1'b1;
            first_n = sel_idx;
            state_n = PICK2;
          end
        end
        PICK2: if (sel_valid) begin
          if (sel_idx == first || face_up[sel_idx]) rej_n = 1'b1;
          else begin
            face_n[sel_idx] = 1'b1;
            second_n = sel_idx;
            att_n = attempts + 8'(attempts != 8'hff);
            state_n = COMPARE;
          end
        end
        COMPARE: begin
          rej_n = sel_valid;
          if (val_a == val_b) begin
            matched_n[first] = 1'b1;
            matched_n[second] = 1'b1;
            pairs_n = pairs_found + 4'd1;
            state_n = pairs_found == 4'd7 ? WIN : PICK1;
          end else begin
            timer_n = TW'(SHOW_CYCLES - 1);
            state_n = SHOW;
          end
        end
        SHOW: begin
          rej_n = sel_valid;
          timer_n = timer == '0 ? '0 : timer - TW'(1);
          if (timer == '0) begin
            face_n[first] = 1'b0;
            face_n[second] = 1'b0;
            state_n = PICK1;
          end
        end
        WIN: begin
          rej_n = sel_valid;
          face_n = '1;
          matched_n = '1;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      map_q <= '0;
      first <= '0;
      second <= '0;
      timer <= '0;
      face_up <= '0;
      matched <= '0;
      attempts <= '0;
      pairs_found <= '0;
      shuffle_start <= 1'b0;
      sel_reject <= 1'b0;
      busy <= 1'b0;
      win <= 1'b0;
    end else begin
      state <= state_n;
      map_q <= map_n;
      first <= first_n;
      second <= second_n;
      timer <= timer_n;
      face_up <= face_n;
      matched <= matched_n;
      attempts <= att_n;
      pairs_found <= pairs_n;
      shuffle_start <= ss_n;
      sel_reject <= rej_n;
      busy <= state_n == WAIT_MAP || state_n == COMPARE || state_n == SHOW;
      win <= state_n == WIN;
    end
  end
endmodule

// File: tb/tb_card_flip_ctrl.sv
// tb_card_flip_ctrl: directed plus random play against a per-cycle game model
module tb_card_flip_ctrl;
  localparam int S = 4;
  logic clk = 1'b0, reset = 1'b1, new_game = 1'b0, sel_valid = 1'b0, map_done = 1'b0;
  logic [3:0] sel_idx = '0;
  logic [47:0] map_in = '0;
  logic shuffle_start, sel_reject, busy, win;
  logic [15:0] face_up, matched;
  logic [7:0] attempts;
  logic [3:0] pairs_found;
  int checks = 0, errors = 0;
  int ph, m_att, m_pairs, m_first, m_second, m_left;
  int m_val[16];
  logic [15:0] m_face, m_match;
  bit m_ss, m_rej;

  always #5 clk = ~clk;

  card_flip_ctrl #(.SHOW_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .new_game(new_game), .sel_valid(sel_valid), .sel_idx(sel_idx),
    .map(map_in), .map_done(map_done), .shuffle_start(shuffle_start), .face_up(face_up),
    .matched(matched), .attempts(attempts), .pairs_found(pairs_found), .sel_reject(sel_reject),
    .busy(busy), .win(win)
  );

  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("face_up", face_up, m_face);
    chk("matched", matched, m_match);
    chk("attempts", 16'(attempts), 16'(m_att));
    chk("pairs_found", 16'(pairs_found), 16'(m_pairs));
    chk("shuffle_start", 16'(shuffle_start), 16'(m_ss));
    chk("sel_reject", 16'(sel_reject), 16'(m_rej));
    chk("busy", 16'(busy), 16'(ph == 1 || ph == 4 || ph == 5));
    chk("win", 16'(win), 16'(ph == 6));
  endtask

  task automatic model_reset();
    ph = 0; m_att = 0; m_pairs = 0; m_first = 0; m_second = 0; m_left = 0;
    m_face = '0; m_match = '0; m_ss = 0; m_rej = 0;
    for (int i = 0; i < 16; i++) m_val[i] = 0;
  endtask

  // phases: 0 idle, 1 waiting for map, 2 first pick, 3 second pick, 4 compare, 5 showing, 6 won
  task automatic model_step(bit ng, bit sv, int idx, bit md, logic [47:0] mp);
    m_ss = 0; m_rej = 0;
    if (ng && ph != 1) begin
      m_ss = 1; m_rej = sv; ph = 1;
      m_face = '0; m_match = '0; m_att = 0; m_pairs = 0;
    end else if (ph == 2) begin
      if (sv && m_face[idx]) m_rej = 1;
      else if (sv) begin m_face[idx] = 1'b1; m_first = idx; ph = 3; end
    end else if (ph == 3) begin
      if (sv && (idx == m_first || m_face[idx])) m_rej = 1;
      else if (sv) begin
        m_face[idx] = 1'b1; m_second = idx; ph = 4;
        m_att = m_att < 255 ? m_att + 1 : 255;
      end
    end else begin
      m_rej = sv;
      if (ph == 1 && md) begin
        for (int i = 0; i < 16; i++) m_val[i] = int'((mp >> (3 * i)) & 48'h7);
        ph = 2;
      end else if (ph == 4) begin
        if (m_val[m_first] == m_val[m_second]) begin
          m_match[m_first] = 1'b1; m_match[m_second] = 1'b1; m_pairs++;
          ph = m_pairs == 8 ? 6 : 2;
        end else begin
          m_left = S; ph = 5;
        end
      end else if (ph == 5) begin
        m_left--;
        if (m_left == 0) begin m_face[m_first] = 1'b0; m_face[m_second] = 1'b0; ph = 2; end
      end
    end
  endtask

  task automatic cyc(bit ng, bit sv, int idx, bit md);
    new_game = ng; sel_valid = sv; sel_idx = 4'(idx); map_done = md;
    @(posedge clk);
    model_step(ng, sv, idx, md, map_in);
    #1 check_all();
    @(negedge clk);
    new_game = 0; sel_valid = 0; map_done = 0;
  endtask

  task automatic sel(int idx);
    cyc(0, 1, idx, 0);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic set_map_m();
    for (int i = 0; i < 16; i++) map_in[3*i +: 3] = 3'(i >> 1);
  endtask

  task automatic start_game();
    set_map_m();
    cyc(1, 0, 0, 0);
    idle(2);
    cyc(0, 0, 0, 1);
    map_in = 48'({$urandom(), $urandom()});
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_all();
    reset = 0;
    @(negedge clk);
    sel(3);
    idle(2);
    // first pair matches, then a mismatch held for S cycles
    start_game();
    sel(0); sel(1); idle(1);
    chk("first_match", matched, 16'h0003);
    chk("first_pairs", 16'(pairs_found), 16'd1);
    sel(2); sel(4); idle(1);
    chk("show_face", face_up & 16'h0014, 16'h0014);
    sel(5); idle(S);
    chk("show_cleared", face_up & 16'h0014, 16'h0000);
    sel(6); sel(6); sel(0); sel(7); idle(1);
    chk("reject_att", 16'(attempts), 16'd3);
    // full winning game
    start_game();
    for (int k = 0; k < 8; k++) begin sel(2*k); sel(2*k+1); idle(1); end
    chk("win_flag", 16'(win), 16'd1);
    chk("win_match", matched, 16'hffff);
    chk("win_att", 16'(attempts), 16'd8);
    sel(1); idle(2);
    cyc(1, 0, 0, 0);
    chk("restart_clear", face_up | matched, 16'h0000);
    idle(1); cyc(0, 0, 0, 1);
    // saturation of the attempt counter
    start_game();
    for (int k = 0; k < 260; k++) begin sel(0); sel(2); idle(S + 1); end
    chk("att_sat", 16'(attempts), 16'd255);
    sel(0);
    cyc(1, 1, 5, 0);
    chk("ng_priority", face_up, 16'h0000);
    idle(1); set_map_m(); cyc(0, 0, 0, 1);
    // asynchronous reset while a mismatch is on display
    sel(0); sel(3); idle(2);
    reset = 1;
    #1 model_reset();
    check_all();
    @(negedge clk);
    reset = 0;
    sel(4);
    // random play
    for (int n = 0; n < 4000; n++) begin
      map_in = 48'({$urandom(), $urandom()});
      if ($urandom_range(0, 3) == 0) set_map_m();
      cyc($urandom_range(0, 149) == 0, $urandom_range(0, 2) == 0, int'($urandom_range(0, 15)),
          $urandom_range(0, 7) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
